// File: rtl/eca_pkg.sv
// ----------------------------------------------------------------------------
// eca_pkg
// Shared types and constants for the elementary cellular automaton row
// sequencer.
//   eca_state_t : sequencer FSM encoding (IDLE, EVAL, COMMIT, DONE)
//   RULE_0X18   : default truth table. Its outputs are 1 only for the
//                 patterns {l,c,r} = 011 and 100.
// ----------------------------------------------------------------------------
package eca_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } eca_state_t;

    localparam logic [7:0] RULE_0X18 = 8'h18;

endpackage : eca_pkg

// File: rtl/eca_rule_cell.sv
// ----------------------------------------------------------------------------
// eca_rule_cell
// Combinational 3-input truth-table lookup: out = rule[{l,c,r}].
// Ports:
//   l, c, r  in   1  left, centre and right neighbour bits
//   rule     in   8  truth table, indexed by {l,c,r}
//   out      out  1  next-generation value of the centre cell
// ----------------------------------------------------------------------------
module eca_rule_cell (
    input  logic       l,
    input  logic       c,
    input  logic       r,
    input  logic [7:0] rule,
    output logic       out
);

    assign out = rule[{l, c, r}];

endmodule : eca_rule_cell

// File: rtl/eca_row_sequencer.sv
// ----------------------------------------------------------------------------
// eca_row_sequencer
// Walks a single rule cell across a WIDTH-cell row, one cell per clock.
// Results are written into a shadow buffer. The buffer is copied into row_out
// in one cycle (COMMIT), so row_out never shows a partial generation. The walk
// repeats for 'steps' generations, and then done pulses for one cycle.
//
// Handshake: the host loads a row when load_valid and load_ready are both high
// at a rising edge. load_ready is high only in IDLE. start and steps are
// sampled only in IDLE. Nothing is queued while a run is active.
//
// Ports:
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset
//   load_valid  in   1      host presents load_data
//   load_ready  out  1      high only in IDLE
//   load_data   in   WIDTH  row to load
//   start       in   1      begin a run (IDLE only)
//   steps       in   8      generations to run, sampled with start
//   busy        out  1      high in EVAL and COMMIT
//   done        out  1      single-cycle completion pulse
//   row_out     out  WIDTH  committed row
//   fsm_state   out  2      current FSM state (observation only)
// ----------------------------------------------------------------------------
module eca_row_sequencer
    import eca_pkg::*;
#(
    parameter int         WIDTH = 16,
    parameter logic [7:0] RULE  = RULE_0X18,
    parameter bit         WRAP  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             start,
    input  logic [7:0]       steps,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] row_out,
    output eca_state_t       fsm_state
);

    localparam int               IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] ONE   = IDX_W'(1);

    eca_state_t       state;
    eca_state_t       state_nx;
    logic [WIDTH-1:0] nxt;
    logic [IDX_W-1:0] idx;
    logic [7:0]       count;

    logic nb_l;
    logic nb_c;
    logic nb_r;
    logic cell_out;

    // Neighbour selection from the committed row. l is the higher index and
    // r is the lower index. At a row edge, the out-of-range neighbour is 0, or
    // it is the opposite end of the row when WRAP is set.
    always_comb begin
        nb_c = row_out[idx];
        if (idx == LAST) begin
            nb_l = WRAP ? row_out[0] : 1'b0;
        end else begin
            nb_l = row_out[idx + ONE];
        end
        if (idx == '0) begin
            nb_r = WRAP ? row_out[WIDTH-1] : 1'b0;
        end else begin
            nb_r = row_out[idx - ONE];
        end
    end

    eca_rule_cell u_cell (
        .l    (nb_l),
        .c    (nb_c),
        .r    (nb_r),
        .rule (RULE),
        .out  (cell_out)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and Moore outputs.
    always_comb begin
        state_nx   = state;
        busy       = 1'b0;
        done       = 1'b0;
        load_ready = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (start) begin
                    state_nx = (steps == 8'd0) ? DONE : EVAL;
                end
            end
            EVAL: begin
                busy = 1'b1;
                if (idx == LAST) begin
                    state_nx = COMMIT;
                end
            end
            COMMIT: begin
                busy = 1'b1;
                // count is decremented in this cycle, so a value of 1 here
                // means this commit is the last generation of the run.
                state_nx = (count == 8'd1) ? DONE : EVAL;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: row register, shadow buffer, cell index, generation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_out <= '0;
            nxt     <= '0;
            idx     <= '0;
            count   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    // When a load and a start arrive together, the run operates
                    // on load_data. EVAL reads row_out only from the next cycle.
                    if (load_valid) begin
                        row_out <= load_data;
                    end
                    if (start && (steps != 8'd0)) begin
                        count <= steps;
                        idx   <= '0;
                    end
                end
                EVAL: begin
                    nxt[idx] <= cell_out;
                    if (idx != LAST) begin
                        idx <= idx + ONE;
                    end
                end
                COMMIT: begin
                    row_out <= nxt;
                    count   <= count - 8'd1;
                    idx     <= '0;
                end
                default: ;
            endcase
        end
    end

    assign fsm_state = state;

endmodule : eca_row_sequencer

// File: tb/tb_eca_row_sequencer.sv
// ----------------------------------------------------------------------------
// tb_eca_row_sequencer
// Directed bench for WIDTH=8 and RULE=8'h18. It drives two instances that
// share every input: u_dut0 uses WRAP=0 and u_dut1 uses WRAP=1.
// ----------------------------------------------------------------------------
module tb_eca_row_sequencer;
    import eca_pkg::*;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         load_valid = 1'b0;
    logic [W-1:0] load_data  = '0;
    logic         start      = 1'b0;
    logic [7:0]   steps      = 8'd0;

    logic         load_ready0, busy0, done0;
    logic         load_ready1, busy1, done1;
    logic [W-1:0] row0, row1;
    eca_state_t   st0, st1;

    eca_row_sequencer #(.WIDTH(W), .RULE(RULE_0X18), .WRAP(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready0),
        .load_data(load_data), .start(start), .steps(steps), .busy(busy0),
        .done(done0), .row_out(row0), .fsm_state(st0)
    );

    eca_row_sequencer #(.WIDTH(W), .RULE(RULE_0X18), .WRAP(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready1),
        .load_data(load_data), .start(start), .steps(steps), .busy(busy1),
        .done(done1), .row_out(row1), .fsm_state(st1)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_row(input logic [W-1:0] row);
        load_valid = 1'b1;
        load_data  = row;
        tick();
        load_valid = 1'b0;
        check("load_row0", row0, row);
        check("load_row1", row1, row);
    endtask

    // Starts a run and counts rising edges until done is high. The edge that
    // accepts start is edge 1, so the done cycle is edge steps*(W+1)+1.
    // If same_cycle_row is set, the row is loaded in the same cycle as start.
    // If interfere is set, load and start are pulsed while the run is active.
    task automatic run(input bit same_cycle_load, input logic [W-1:0] row,
                       input logic [7:0] s, input bit interfere,
                       output int lat, output int busy_cnt);
        lat      = -1;
        busy_cnt = 0;
        start    = 1'b1;
        steps    = s;
        if (same_cycle_load) begin
            load_valid = 1'b1;
            load_data  = row;
        end
        for (int n = 1; n <= 5000; n++) begin
            tick();
            if (n == 1) begin
                start      = 1'b0;
                load_valid = 1'b0;
            end
            if (interfere && n >= 4 && n <= 6) begin
                load_valid = 1'b1;
                load_data  = 8'hFF;
                start      = 1'b1;
                steps      = 8'd1;
                if (n == 4) check("ready_low_mid_run", load_ready0, 1'b0);
            end
            if (interfere && n == 7) begin
                load_valid = 1'b0;
                start      = 1'b0;
            end
            if (busy0) busy_cnt++;
            if (done0) begin
                lat = n;
                check("done1_aligned", done1, 1'b1);
                break;
            end
        end
        if (lat < 0) check("done_timeout", 32'd0, 32'd1);
        // The done pulse lasts exactly one cycle and is followed by IDLE.
        tick();
        check("done_one_cycle", done0, 1'b0);
        check("ready_after_done", load_ready0, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    int lat, bc;

    initial begin
        // Check the reset values.
        #12;
        check("rst_row", row0, 8'h00);
        check("rst_busy", busy0, 1'b0);
        check("rst_done", done0, 1'b0);
        rst_n = 1'b1;
        tick();
        check("rst_ready", load_ready0, 1'b1);

        // Test 1: row 0000_0011, one step, done 10 cycles after start.
        // With WRAP=1, cell 7 sees l=row[0]=1 (pattern 100), so it becomes 1.
        load_row(8'b0000_0011);
        run(1'b0, '0, 8'd1, 1'b0, lat, bc);
        check("t1_latency", lat, 10);
        check("t1_row0", row0, 8'b0000_0010);
        check("t1_row1", row1, 8'b1000_0010);

        // Test 2: a single 1 shifts down by one cell per step.
        load_row(8'b0001_0000);
        run(1'b0, '0, 8'd4, 1'b0, lat, bc);
        check("t2_latency", lat, 37);
        check("t2_busy_cycles", bc, 36);
        check("t2_row0", row0, 8'b0000_0001);
        check("t2_row1", row1, 8'b0000_0001);

        // Test 3: the fifth step leaves the row (WRAP=0) or wraps around (WRAP=1).
        load_row(8'b0001_0000);
        run(1'b0, '0, 8'd5, 1'b0, lat, bc);
        check("t3_latency", lat, 46);
        check("t3_row0", row0, 8'b0000_0000);
        check("t3_row1", row1, 8'b1000_0000);

        // Test 4: with steps=0, done comes at once and the row is unchanged.
        load_row(8'hA5);
        run(1'b0, '0, 8'd0, 1'b0, lat, bc);
        check("t4_latency", lat, 1);
        check("t4_busy_cycles", bc, 0);
        check("t4_row0", row0, 8'hA5);

        // Test 5: load and start pulses during a run are ignored.
        load_row(8'b0001_0000);
        run(1'b0, '0, 8'd4, 1'b1, lat, bc);
        check("t5_latency", lat, 37);
        check("t5_row0", row0, 8'b0000_0001);

        // Test 7: load and start in the same cycle; the run uses the new row.
        // 0000_1100: cell1 sees 100 -> 1, cell3 sees 011 -> 1, others 0.
        run(1'b1, 8'b0000_1100, 8'd1, 1'b0, lat, bc);
        check("t7_latency", lat, 10);
        check("t7_row0", row0, 8'b0000_1010);
        check("t7_row1", row1, 8'b0000_1010);

        // Test 6: reset during EVAL aborts the run with no done pulse.
        load_row(8'b0001_0000);
        start = 1'b1;
        steps = 8'd4;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("t6_in_eval", st0, EVAL);
        rst_n = 1'b0;
        #1;
        check("t6_rst_row", row0, 8'h00);
        check("t6_rst_busy", busy0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t6_no_done", done0, 1'b0);
        end
        rst_n = 1'b1;
        tick();
        check("t6_ready", load_ready0, 1'b1);
        load_row(8'b0000_0011);
        run(1'b0, '0, 8'd1, 1'b0, lat, bc);
        check("t6_rerun_latency", lat, 10);
        check("t6_rerun_row0", row0, 8'b0000_0010);

        // Test 8: steps=255. The single bit rotates with period 8 when WRAP=1.
        // 255 mod 8 = 7, so the bit moves from position 0 to position 1.
        load_row(8'b0000_0001);
        run(1'b0, '0, 8'd255, 1'b0, lat, bc);
        check("t8_latency", lat, 255 * 9 + 1);
        check("t8_row0", row0, 8'h00);
        check("t8_row1", row1, 8'h02);

        // ---------------- final report ----------------
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_eca_row_sequencer
